// File: rtl/seg7_nios2_qsys_ocimem_arbiter.sv
// seg7_nios2_qsys_ocimem_arbiter
// Shares the single-port OCI RAM between the JTAG debug path and the CPU
// Avalon slave port. One access is in flight at a time:
// IDLE -> ACC -> (RD_WAIT for reads) -> IDLE.
//
// Ports
//   clk, reset          single clock, asynchronous active-high reset
//   jtag_addr_set/addr  load the JTAG address pointer
//   jtag_op/wr/wdata    request one JTAG access (pointer post-increments)
//   jtag_rdata/done     last JTAG read result, one-cycle completion pulse
//   jtag_overrun        sticky: a JTAG command arrived while JTAG was busy
//   cpu_*               Avalon-MM slave (waitrequest style)
//   ram_*               registered RAM control, ram_rdata one-cycle latency
//
// Build option: define OCIMEM_ARB_FIXED_PRIO_EN to give JTAG absolute
// priority over the CPU; otherwise requesters alternate on contention.
module seg7_nios2_qsys_ocimem_arbiter #(
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              jtag_addr_set,
    input  logic [ADDR_W-1:0] jtag_addr,
    input  logic              jtag_op,
    input  logic              jtag_wr,
    input  logic [31:0]       jtag_wdata,
    output logic [31:0]       jtag_rdata,
    output logic              jtag_done,
    output logic              jtag_overrun,
    input  logic [ADDR_W-1:0] cpu_address,
    input  logic              cpu_read,
    input  logic              cpu_write,
    input  logic [31:0]       cpu_writedata,
    input  logic [3:0]        cpu_byteenable,
    output logic [31:0]       cpu_readdata,
    output logic              cpu_waitrequest,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_wren,
    output logic [3:0]        ram_byteen,
    output logic [31:0]       ram_wdata,
    input  logic [31:0]       ram_rdata
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACC     = 2'd1,
        S_RD_WAIT = 2'd2
    } state_t;

    state_t            state, state_nxt;
    logic              jtag_pend, pend_wr;
    logic [31:0]       pend_wdata;
    logic [ADDR_W-1:0] ptr;
    logic              gnt_jtag, gnt_wr;
    logic              take_jtag, take_cpu, arb_jtag_wins;

    // JTAG request qualification: a fresh op may be granted in the cycle it arrives
    logic              cpu_req, jtag_free, op_acc, set_acc, jtag_req;
    logic              jtag_wr_eff;
    logic [31:0]       jtag_wdata_eff;
    logic [ADDR_W-1:0] jtag_addr_eff;

    assign cpu_req        = cpu_read | cpu_write;
    assign jtag_free      = !jtag_pend && !((state != S_IDLE) && gnt_jtag);
    assign op_acc         = jtag_op && jtag_free;
    assign set_acc        = jtag_addr_set && jtag_free;
    assign jtag_req       = jtag_pend | op_acc;
    assign jtag_addr_eff  = set_acc ? jtag_addr : ptr;
    assign jtag_wr_eff    = jtag_pend ? pend_wr : jtag_wr;
    assign jtag_wdata_eff = jtag_pend ? pend_wdata : jtag_wdata;

    // Contention winner
`ifdef OCIMEM_ARB_FIXED_PRIO_EN
    assign arb_jtag_wins = 1'b1;
`else
    logic last_jtag;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_jtag <= 1'b0;
        end else if (take_jtag) begin
            last_jtag <= 1'b1;
        end else if (take_cpu) begin
            last_jtag <= 1'b0;
        end
    end

    assign arb_jtag_wins = !last_jtag;
`endif

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and grant decision
    always_comb begin
        state_nxt = state;
        take_jtag = 1'b0;
        take_cpu  = 1'b0;
        case (state)
            S_IDLE: begin
                if (jtag_req && cpu_req) begin
                    take_jtag = arb_jtag_wins;
                    take_cpu  = !arb_jtag_wins;
                end else begin
                    take_jtag = jtag_req;
                    take_cpu  = cpu_req;
                end
                if (jtag_req || cpu_req) begin
                    state_nxt = S_ACC;
                end
            end
            S_ACC:     state_nxt = gnt_wr ? S_IDLE : S_RD_WAIT;
            S_RD_WAIT: state_nxt = S_IDLE;
            default:   state_nxt = S_IDLE;
        endcase
    end

    // Grant registers, RAM control, JTAG pointer and status
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            jtag_pend    <= 1'b0;
            pend_wr      <= 1'b0;
            pend_wdata   <= '0;
            ptr          <= '0;
            gnt_jtag     <= 1'b0;
            gnt_wr       <= 1'b0;
            ram_addr     <= '0;
            ram_wren     <= 1'b0;
            ram_byteen   <= '0;
            ram_wdata    <= '0;
            jtag_rdata   <= '0;
            jtag_done    <= 1'b0;
            jtag_overrun <= 1'b0;
        end else begin
            ram_wren  <= 1'b0;
            jtag_done <= gnt_jtag && (((state == S_ACC) && gnt_wr) || (state == S_RD_WAIT));

            if ((state == S_RD_WAIT) && gnt_jtag) begin
                jtag_rdata <= ram_rdata;
            end
            if ((jtag_op || jtag_addr_set) && !jtag_free) begin
                jtag_overrun <= 1'b1;
            end

            if (take_jtag) begin
                ptr <= ADDR_W'(jtag_addr_eff + ADDR_W'(1));
            end else if (set_acc) begin
                ptr <= jtag_addr;
            end

            if (take_jtag) begin
                jtag_pend <= 1'b0;
            end else if (op_acc) begin
                jtag_pend <= 1'b1;
            end
            if (op_acc) begin
                pend_wr    <= jtag_wr;
                pend_wdata <= jtag_wdata;
            end

            if (take_jtag) begin
                gnt_jtag   <= 1'b1;
                gnt_wr     <= jtag_wr_eff;
                ram_addr   <= jtag_addr_eff;
                ram_wren   <= jtag_wr_eff;
                ram_byteen <= 4'hF;
                ram_wdata  <= jtag_wdata_eff;
            end else if (take_cpu) begin
                // read+write together is treated as a write
                gnt_jtag   <= 1'b0;
                gnt_wr     <= cpu_write;
                ram_addr   <= cpu_address;
                ram_wren   <= cpu_write;
                ram_byteen <= cpu_byteenable;
                ram_wdata  <= cpu_writedata;
            end
        end
    end

    // Avalon response: write completes in ACC, read completes in RD_WAIT
    logic cpu_done_c;
    assign cpu_done_c      = !gnt_jtag && (((state == S_ACC) && gnt_wr) || (state == S_RD_WAIT));
    assign cpu_waitrequest = cpu_req && !cpu_done_c;
    assign cpu_readdata    = ((state == S_RD_WAIT) && !gnt_jtag) ? ram_rdata : '0;

endmodule

// File: tb/tb_seg7_nios2_qsys_ocimem_arbiter.sv
// Bench for seg7_nios2_qsys_ocimem_arbiter: per-cycle vector table plus
// hand-written sequences for arbitration order and reset during an access.
module tb_seg7_nios2_qsys_ocimem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        jtag_addr_set;
    logic [7:0]  jtag_addr;
    logic        jtag_op;
    logic        jtag_wr;
    logic [31:0] jtag_wdata;
    logic [31:0] jtag_rdata;
    logic        jtag_done;
    logic        jtag_overrun;
    logic [7:0]  cpu_address;
    logic        cpu_read;
    logic        cpu_write;
    logic [31:0] cpu_writedata;
    logic [3:0]  cpu_byteenable;
    logic [31:0] cpu_readdata;
    logic        cpu_waitrequest;
    logic [7:0]  ram_addr;
    logic        ram_wren;
    logic [3:0]  ram_byteen;
    logic [31:0] ram_wdata;
    logic [31:0] ram_rdata;

    always #5 clk = ~clk;

    seg7_nios2_qsys_ocimem_arbiter #(.ADDR_W(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .jtag_addr_set  (jtag_addr_set),
        .jtag_addr      (jtag_addr),
        .jtag_op        (jtag_op),
        .jtag_wr        (jtag_wr),
        .jtag_wdata     (jtag_wdata),
        .jtag_rdata     (jtag_rdata),
        .jtag_done      (jtag_done),
        .jtag_overrun   (jtag_overrun),
        .cpu_address    (cpu_address),
        .cpu_read       (cpu_read),
        .cpu_write      (cpu_write),
        .cpu_writedata  (cpu_writedata),
        .cpu_byteenable (cpu_byteenable),
        .cpu_readdata   (cpu_readdata),
        .cpu_waitrequest(cpu_waitrequest),
        .ram_addr       (ram_addr),
        .ram_wren       (ram_wren),
        .ram_byteen     (ram_byteen),
        .ram_wdata      (ram_wdata),
        .ram_rdata      (ram_rdata)
    );

    // RAM model: byte-enabled write, one-cycle registered read
    logic [31:0] mem [256];

    always @(posedge clk) begin
        if (ram_wren) begin
            for (int b = 0; b < 4; b++) begin
                if (ram_byteen[b]) mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
            end
        end
        ram_rdata <= mem[ram_addr];
    end

    typedef struct {
        logic        rst, aset, op, wr, crd, cwr;
        logic [7:0]  aaddr, caddr;
        logic [31:0] wd, cwd;
        logic [3:0]  be;
        logic        e_wren, ca, e_done, e_wait, e_ovr;
        logic [7:0]  e_addr;
        int          cr;      // 0 none, 1 cpu_readdata, 2 jtag_rdata
        logic [31:0] e_rd;
    } vec_t;

    vec_t tbl[$];
    int   n_chk = 0;
    int   n_err = 0;

    function automatic vec_t nop();
        vec_t v;
        v = '{rst: 1'b0, aset: 1'b0, op: 1'b0, wr: 1'b0, crd: 1'b0, cwr: 1'b0,
              aaddr: 8'h0, caddr: 8'h0, wd: 32'h0, cwd: 32'h0, be: 4'h0,
              e_wren: 1'b0, ca: 1'b0, e_done: 1'b0, e_wait: 1'b0, e_ovr: 1'b0,
              e_addr: 8'h0, cr: 0, e_rd: 32'h0};
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic clear_inputs();
        jtag_addr_set = 1'b0; jtag_addr = 8'h0; jtag_op = 1'b0; jtag_wr = 1'b0;
        jtag_wdata = 32'h0; cpu_read = 1'b0; cpu_write = 1'b0; cpu_address = 8'h0;
        cpu_writedata = 32'h0; cpu_byteenable = 4'h0;
    endtask

    task automatic fill_table();
        vec_t v;
        v = nop(); v.rst = 1; tbl.push_back(v);                                   // 0 reset state
        v = nop(); v.rst = 1; v.cwr = 1; v.caddr = 8'h30; v.e_wait = 1; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        // JTAG write 0x10
        v = nop(); v.aset = 1; v.aaddr = 8'h10; v.op = 1; v.wr = 1; v.wd = 32'hDEADBEEF; tbl.push_back(v);
        v = nop(); v.e_wren = 1; v.ca = 1; v.e_addr = 8'h10; tbl.push_back(v);
        v = nop(); v.e_done = 1; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        // JTAG read uses post-incremented pointer 0x11
        v = nop(); v.op = 1; tbl.push_back(v);
        v = nop(); v.ca = 1; v.e_addr = 8'h11; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        v = nop(); v.e_done = 1; v.cr = 2; v.e_rd = 32'hA0000011; tbl.push_back(v);
        // read back 0x10
        v = nop(); v.aset = 1; v.aaddr = 8'h10; v.op = 1; tbl.push_back(v);
        v = nop(); v.ca = 1; v.e_addr = 8'h10; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        v = nop(); v.e_done = 1; v.cr = 2; v.e_rd = 32'hDEADBEEF; tbl.push_back(v);
        // CPU read 0x20
        v = nop(); v.crd = 1; v.caddr = 8'h20; v.be = 4'hF; v.e_wait = 1; tbl.push_back(v);
        v = nop(); v.crd = 1; v.caddr = 8'h20; v.be = 4'hF; v.e_wait = 1; v.ca = 1; v.e_addr = 8'h20; tbl.push_back(v);
        v = nop(); v.crd = 1; v.caddr = 8'h20; v.be = 4'hF; v.cr = 1; v.e_rd = 32'h12345678; tbl.push_back(v);
        v = nop(); v.cr = 1; v.e_rd = 32'h0; tbl.push_back(v);
        // read+write together acts as write, low two bytes only
        v = nop(); v.crd = 1; v.cwr = 1; v.caddr = 8'h21; v.cwd = 32'h55667788; v.be = 4'h3; v.e_wait = 1; tbl.push_back(v);
        v = nop(); v.crd = 1; v.cwr = 1; v.caddr = 8'h21; v.cwd = 32'h55667788; v.be = 4'h3;
        v.e_wren = 1; v.ca = 1; v.e_addr = 8'h21; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        v = nop(); v.crd = 1; v.caddr = 8'h21; v.be = 4'hF; v.e_wait = 1; tbl.push_back(v);
        v = nop(); v.crd = 1; v.caddr = 8'h21; v.be = 4'hF; v.e_wait = 1; v.ca = 1; v.e_addr = 8'h21; tbl.push_back(v);
        v = nop(); v.crd = 1; v.caddr = 8'h21; v.be = 4'hF; v.cr = 1; v.e_rd = 32'hA0007788; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
        // pointer 0xFF read, second op dropped while in flight
        v = nop(); v.aset = 1; v.aaddr = 8'hFF; v.op = 1; tbl.push_back(v);
        v = nop(); v.op = 1; v.ca = 1; v.e_addr = 8'hFF; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; v.e_done = 1; v.cr = 2; v.e_rd = 32'hCAFEF00D; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; tbl.push_back(v);
        // pointer wrapped to 0x00
        v = nop(); v.op = 1; v.e_ovr = 1; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; v.ca = 1; v.e_addr = 8'h00; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; tbl.push_back(v);
        v = nop(); v.e_ovr = 1; v.e_done = 1; v.cr = 2; v.e_rd = 32'hA0000000; tbl.push_back(v);
        // reset clears overrun and read data immediately
        v = nop(); v.rst = 1; v.cr = 2; v.e_rd = 32'h0; tbl.push_back(v);
        v = nop(); tbl.push_back(v);
    endtask

    task automatic run_table();
        foreach (tbl[i]) begin
            @(negedge clk);
            reset = tbl[i].rst; jtag_addr_set = tbl[i].aset; jtag_addr = tbl[i].aaddr;
            jtag_op = tbl[i].op; jtag_wr = tbl[i].wr; jtag_wdata = tbl[i].wd;
            cpu_read = tbl[i].crd; cpu_write = tbl[i].cwr; cpu_address = tbl[i].caddr;
            cpu_writedata = tbl[i].cwd; cpu_byteenable = tbl[i].be;
            #1;
            chk($sformatf("v%0d ram_wren", i), 32'(ram_wren), 32'(tbl[i].e_wren));
            chk($sformatf("v%0d jtag_done", i), 32'(jtag_done), 32'(tbl[i].e_done));
            chk($sformatf("v%0d cpu_waitrequest", i), 32'(cpu_waitrequest), 32'(tbl[i].e_wait));
            chk($sformatf("v%0d jtag_overrun", i), 32'(jtag_overrun), 32'(tbl[i].e_ovr));
            if (tbl[i].ca) chk($sformatf("v%0d ram_addr", i), 32'(ram_addr), 32'(tbl[i].e_addr));
            if (tbl[i].cr == 1) chk($sformatf("v%0d cpu_readdata", i), cpu_readdata, tbl[i].e_rd);
            if (tbl[i].cr == 2) chk($sformatf("v%0d jtag_rdata", i), jtag_rdata, tbl[i].e_rd);
        end
    endtask

    task automatic do_reset();
        @(negedge clk); reset = 1'b1; clear_inputs();
        @(negedge clk); reset = 1'b0;
    endtask

    // Reset asserted mid-ACC of a write must abort it with no write and no done
    task automatic reset_during_acc(input bit use_jtag, input logic [7:0] addr, input logic [31:0] orig);
        string tag;
        tag = use_jtag ? "abort_jtag" : "abort_cpu";
        do_reset();
        @(negedge clk);
        if (use_jtag) begin
            jtag_op = 1'b1; jtag_wr = 1'b1; jtag_wdata = 32'hFFFFFFFF;
        end else begin
            cpu_write = 1'b1; cpu_address = addr; cpu_writedata = 32'hFFFFFFFF; cpu_byteenable = 4'hF;
        end
        @(negedge clk);
        jtag_op = 1'b0;
        #1;
        chk({tag, " wren_in_acc"}, 32'(ram_wren), 32'd1);
        chk({tag, " addr_in_acc"}, 32'(ram_addr), 32'(addr));
        reset = 1'b1;
        #1;
        chk({tag, " wren_at_reset"}, 32'(ram_wren), 32'd0);
        chk({tag, " idle_waitreq"}, 32'(cpu_waitrequest), use_jtag ? 32'd0 : 32'd1);
        chk({tag, " done_at_reset"}, 32'(jtag_done), 32'd0);
        chk({tag, " overrun"}, 32'(jtag_overrun), 32'd0);
        @(negedge clk);
        reset = 1'b0; cpu_write = 1'b0;
        for (int c = 0; c < 4; c++) begin
            #1;
            chk($sformatf("%s done_after_c%0d", tag, c), 32'(jtag_done), 32'd0);
            chk($sformatf("%s wren_after_c%0d", tag, c), 32'(ram_wren), 32'd0);
            @(negedge clk);
        end
        chk({tag, " mem_untouched"}, mem[addr], orig);
    endtask

    // Simultaneous JTAG op and CPU write after reset, then a repeat collision
    task automatic arb_order();
        logic [7:0] order[$];
        logic [7:0] exp_order[3];
        bit         hold;
        int         dones;
`ifdef OCIMEM_ARB_FIXED_PRIO_EN
        exp_order = '{8'h00, 8'h01, 8'h30};
`else
        exp_order = '{8'h00, 8'h30, 8'h01};
`endif
        do_reset();
        hold  = 1'b1;
        dones = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            jtag_op = (c == 0) || (c == 2); jtag_wr = 1'b1; jtag_wdata = 32'(c);
            cpu_write = hold; cpu_address = 8'h30; cpu_writedata = 32'h0BADCAFE; cpu_byteenable = 4'hF;
            #1;
            if (ram_wren) order.push_back(ram_addr);
            if (jtag_done) dones++;
            if (c == 2) chk("arb first_done_c2", 32'(jtag_done), 32'd1);
            if (cpu_write && !cpu_waitrequest) hold = 1'b0;
        end
        clear_inputs();
        chk("arb grant_count", 32'(order.size()), 32'd3);
        for (int k = 0; k < 3; k++) begin
            if (k < order.size()) chk($sformatf("arb grant%0d_addr", k), 32'(order[k]), 32'(exp_order[k]));
        end
        chk("arb done_count", 32'(dones), 32'd2);
        chk("arb overrun", 32'(jtag_overrun), 32'd0);
    endtask

    initial begin
        reset = 1'b1;
        clear_inputs();
        for (int i = 0; i < 256; i++) mem[i] = 32'hA0000000 | 32'(i);
        mem[8'h20] = 32'h12345678;
        mem[8'hFF] = 32'hCAFEF00D;
        fill_table();
        run_table();
        reset_during_acc(1'b0, 8'h40, 32'hA0000040);
        reset_during_acc(1'b1, 8'h00, 32'hA0000000);
        arb_order();
        $display("== %0d vectors applied, %0d miscompares ==", n_chk, n_err);
        $finish;
    end

endmodule
